adder16_seq: RTL



---
 rtl/adder16_seq_if.sv | 41 ++++
 rtl/adder16_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/adder16_seq_if.sv
// adder16_seq_if: operand and result handshakes for adder16_seq.
// The ovf signal exists only when ADDER16_OVF_EN is defined.
interface adder16_seq_if #(
  parameter int HALF_W = 8
);
  localparam int W = 2 * HALF_W;

  // Operand side
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;

  // Result side
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
`ifdef ADDER16_OVF_EN
  logic         ovf;
`endif

  // Driver of operands and consumer of results
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout
`ifdef ADDER16_OVF_EN
    , input ovf
`endif
  );

  // The adder stage itself
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout
`ifdef ADDER16_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/adder16_seq.sv
// adder16_seq: 16-bit add performed in two passes through one HALF_W-bit
// slice (low byte, then high byte with the registered carry). Results are
// held until the consumer accepts them.
// Optional feature: define ADDER16_OVF_EN to add the signed-overflow flag.
module adder16_seq #(
  parameter int HALF_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  adder16_seq_if.slave  bus
);
  localparam int W = 2 * HALF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_cin;
  logic [HALF_W-1:0] r_lo;
  logic              r_c8;
  logic [W-1:0]      r_s;
  logic              r_cout;

  logic [HALF_W-1:0] w_slice_a;
  logic [HALF_W-1:0] w_slice_b;
  logic              w_slice_c;
  logic [HALF_W:0]   w_slice_sum;
  logic              w_accept;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: fixed LOW->HIGH->DONE walk, waits in IDLE and DONE
  always_comb begin
    // NOTE: default first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid)  w_next = S_LOW;
      S_LOW:                      w_next = S_HIGH;
      S_HIGH:                     w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);

  // Operand capture on the input handshake
  always_ff @(posedge clk) begin
    // NOTE: operand registers carry no reset; they are always loaded on
    // accept before the slice reads them, so reset would only cost area.
    if (w_accept && !rst) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_cin <= bus.cin;
    end
  end

  // Slice operand select: low halves in LOW, high halves in HIGH
  always_comb begin
    w_slice_a = r_a[HALF_W-1:0];
    w_slice_b = r_b[HALF_W-1:0];
    w_slice_c = r_cin;
    if (r_state == S_HIGH) begin
      w_slice_a = r_a[W-1:HALF_W];
      w_slice_b = r_b[W-1:HALF_W];
      w_slice_c = r_c8;
    end
  end

  // The single shared HALF_W-bit adder; bit HALF_W is its carry out
  assign w_slice_sum = {1'b0, w_slice_a} + {1'b0, w_slice_b}
                     + {{HALF_W{1'b0}}, w_slice_c};

  // Partial and final result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo   <= '0;
      r_c8   <= 1'b0;
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      if (r_state == S_LOW) begin
        r_lo <= w_slice_sum[HALF_W-1:0];
        r_c8 <= w_slice_sum[HALF_W];
      end
      if (r_state == S_HIGH) begin
        r_s    <= {w_slice_sum[HALF_W-1:0], r_lo};
        r_cout <= w_slice_sum[HALF_W];
      end
    end
  end

  assign bus.s    = r_s;
  assign bus.cout = r_cout;

`ifdef ADDER16_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Signed overflow: like-signed operands giving a result of the other sign
  assign w_ovf = (r_a[W-1] == r_b[W-1]) && (w_slice_sum[HALF_W-1] != r_a[W-1]);

  // Overflow flag, loaded and held alongside s/cout
  always_ff @(posedge clk) begin
    if (rst)                    r_ovf <= 1'b0;
    else if (r_state == S_HIGH) r_ovf <= w_ovf;
  end

  assign bus.ovf = r_ovf;
`endif

endmodule
